sequential_pulse_monitor: RTL
=============================

// Module: sequential_pulse_monitor
// PURPOSE
//   Receive side of the sequential pulse interface: samples the one-hot rotating
//   pulse vector driven by sequential_pulse, locks to the rotation, and reports
//   the current phase index. Every departure from the legal sequence is flagged
//   and counted. It sits downstream of the generator, either as an on-chip checker
//   or as the phase decoder for logic that must act per pulse slot.
// PARAMETERS
//   WIDTH       6  number of pulse lines; legal pattern is one-hot over WIDTH bits
//   STEP_CYCLES 1  clk cycles each bit stays high before the rotation advances
//   LOCK_STEPS  3  correct consecutive advances required in CHECK before LOCKED
//   ERR_CNT_W   8  width of the saturating error counter
// PORTS
//   clk        in   1                  system clock, rising edge
//   rst_n      in   1                  asynchronous, active-low reset
//   pulse_in   in   WIDTH              pulse vector from the generator (pulse_out)
//   clr_err    in   1                  synchronous clear of err_cnt
//   phase_idx  out  $clog2(WIDTH)      index of the high bit in the checked sample
//   locked     out  1                  1 while in LOCKED state
//   err_pulse  out  1                  one-cycle strobe per sequence error while locked
//   err_cnt    out  ERR_CNT_W          saturating count of err_pulse events
// BEHAVIOUR
//   Reset: rst_n=0 clears immediately: state=HUNT, phase_idx=0, locked=0,
//     err_pulse=0, err_cnt=0, sample reg=0, dwell=0, good_steps=0.
//   Pipeline: pulse_in registered into s; FSM evaluates s; all outputs registered.
//     A pattern on pulse_in before edge N is reflected on outputs after edge N+1.
//   Legal sample: exactly one bit of s set; zero or multiple bits set = illegal.
//   dwell: cycles spent at the current index (1..STEP_CYCLES).
//   Expected next sample: same index if dwell<STEP_CYCLES; index+1 if
//     dwell==STEP_CYCLES, wrapping WIDTH-1 -> 0. Any other sample = mismatch
//     (illegal pattern, skipped/backward index, or held too long).
//   HUNT: wait for a legal k -> (k+1)%WIDTH transition between two consecutive
//     samples; then load idx=k+1, dwell=1, good_steps=0, go to CHECK. No errors reported.
//   CHECK: expected sample -> update idx/dwell; each advance increments good_steps.
//     good_steps==LOCK_STEPS -> LOCKED. Mismatch -> HUNT, no err_pulse.
//   LOCKED: expected sample -> track idx; phase_idx=idx; locked=1.
//     Mismatch -> err_pulse=1 for one cycle, err_cnt+1 (saturate at all-ones),
//     locked=0, state=HUNT (a mismatch sample that is itself a legal successor
//     transition is not reused; relock needs a fresh transition).
//   phase_idx updates in CHECK and LOCKED; holds last value in HUNT.
//   clr_err: err_cnt<=0 next edge; if coincident with an error, err_cnt<=1 and
//     err_pulse still fires. Saturated counter stays at max without wrap.
//   Reset mid-operation: async return to reset values; no partial state survives.
// TESTING
//   (WIDTH=6, STEP_CYCLES=1, LOCK_STEPS=3 unless stated)
//   1 Release reset, drive rotation 000001,000010,... one per clk -> locked=1
//     2 clk after the 4th advance seen on pulse_in; phase_idx tracks with 2-cycle lag.
//   2 While locked drive 000000 for one cycle -> err_pulse=1 one cycle, err_cnt=1,
//     locked=0; resume rotation -> relock after 1 transition + 3 advances.
//   3 While locked skip 000001 -> 000100 -> err_pulse, err_cnt increments; repeat
//     with 001001 (two bits) -> second error, err_cnt=2.
//   4 Wrap 100000 -> 000001 while locked -> no err_pulse, phase_idx 5 -> 0.
//   5 STEP_CYCLES=3: hold each bit 3 clk -> locks, no errors; hold one bit 4 clk ->
//     one err_pulse. Force 260 errors (ERR_CNT_W=8) -> err_cnt=255; clr_err on an
//     error cycle -> err_cnt=1.
//   6 Assert rst_n low mid-lock, between edges -> locked, err_cnt, phase_idx go 0
//     without a clock edge; after release, state HUNT.

Source files
------------

// File: rtl/sequential_pulse_monitor_if.sv
// Bundle between the sequential pulse source side and the monitor: the sampled
// pulse vector plus error-clear in, decoded phase and error reporting out.
interface sequential_pulse_monitor_if #(
    parameter int WIDTH     = 6,
    parameter int ERR_CNT_W = 8
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]     pulse_in;
    logic                 clr_err;
    logic [IDX_W-1:0]     phase_idx;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output pulse_in,
        output clr_err,
        input  phase_idx,
        input  locked,
        input  err_pulse,
        input  err_cnt
    );

    modport slave (
        input  pulse_in,
        input  clr_err,
        output phase_idx,
        output locked,
        output err_pulse,
        output err_cnt
    );
endinterface

// File: rtl/sequential_pulse_monitor.sv
// Locks onto a one-hot rotating pulse vector, reports the current phase index and
// flags/counts every departure from the legal rotation once locked.
module sequential_pulse_monitor #(
    parameter int WIDTH       = 6,
    parameter int STEP_CYCLES = 1,
    parameter int LOCK_STEPS  = 3,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sequential_pulse_monitor_if.slave bus
);
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DWELL_W = $clog2(STEP_CYCLES + 1);
    localparam int GOOD_W  = $clog2(LOCK_STEPS + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(STEP_CYCLES);
    localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(LOCK_STEPS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     s_reg;
    logic [WIDTH-1:0]     prev_reg;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DWELL_W-1:0]   dwell_reg, dwell_next;
    logic [GOOD_W-1:0]    good_reg, good_next;
    logic [IDX_W-1:0]     phase_reg, phase_next;
    logic                 locked_reg, locked_next;
    logic                 err_reg, err_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

    function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Bit-position decode of the current and previous samples; only meaningful
    // when the sample is one-hot, which the legality flags qualify.
    logic [IDX_W-1:0] s_terms    [WIDTH];
    logic [IDX_W-1:0] prev_terms [WIDTH];
    logic [IDX_W-1:0] s_idx;
    logic [IDX_W-1:0] prev_idx;
    logic             s_legal;
    logic             prev_legal;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign s_terms[gi]    = s_reg[gi]    ? IDX_W'(gi) : '0;
            assign prev_terms[gi] = prev_reg[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        s_idx    = '0;
        prev_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_idx    = s_idx | s_terms[i];
            prev_idx = prev_idx | prev_terms[i];
        end
    end

    assign s_legal    = (s_reg != '0) && ((s_reg & (s_reg - WIDTH'(1))) == '0);
    assign prev_legal = (prev_reg != '0) && ((prev_reg & (prev_reg - WIDTH'(1))) == '0);

    logic dwell_done;
    logic s_is_same;
    logic s_is_next;
    logic s_expected;
    logic hunt_hit;

    assign dwell_done = (dwell_reg == DWELL_MAX);
    assign s_is_same  = s_legal && (s_idx == idx_reg);
    assign s_is_next  = s_legal && (s_idx == succ(idx_reg));
    assign s_expected = dwell_done ? s_is_next : s_is_same;
    assign hunt_hit   = prev_legal && s_legal && (s_idx == succ(prev_idx));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dwell_next = dwell_reg;
        good_next  = good_reg;
        phase_next = phase_reg;
        err_next   = 1'b0;
        unique case (state_reg)
            HUNT: begin
                if (hunt_hit) begin
                    state_next = CHECK;
                    idx_next   = s_idx;
                    dwell_next = DWELL_W'(1);
                    good_next  = '0;
                    phase_next = s_idx;
                end
            end
            CHECK, LOCKED: begin
                if (s_expected) begin
                    idx_next   = s_idx;
                    phase_next = s_idx;
                    if (dwell_done) begin
                        dwell_next = DWELL_W'(1);
                        if (state_reg == CHECK) begin
                            good_next = good_reg + GOOD_W'(1);
                            if (good_reg == GOOD_LAST) begin
                                state_next = LOCKED;
                            end
                        end
                    end else begin
                        dwell_next = dwell_reg + DWELL_W'(1);
                    end
                end else begin
                    // The offending sample is consumed here, so HUNT needs a fresh pair.
                    state_next = HUNT;
                    err_next   = (state_reg == LOCKED);
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
        locked_next = (state_next == LOCKED);
    end

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (bus.clr_err) begin
            err_cnt_next = err_next ? ERR_CNT_W'(1) : '0;
        end else if (err_next && !(&err_cnt_reg)) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= HUNT;
            s_reg       <= '0;
            prev_reg    <= '0;
            idx_reg     <= '0;
            dwell_reg   <= '0;
            good_reg    <= '0;
            phase_reg   <= '0;
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            s_reg       <= bus.pulse_in;
            prev_reg    <= s_reg;
            idx_reg     <= idx_next;
            dwell_reg   <= dwell_next;
            good_reg    <= good_next;
            phase_reg   <= phase_next;
            locked_reg  <= locked_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign bus.phase_idx = phase_reg;
    assign bus.locked    = locked_reg;
    assign bus.err_pulse = err_reg;
    assign bus.err_cnt   = err_cnt_reg;

endmodule
